fnd_disp_scheduler: RTL
=======================

Name: fnd_disp_scheduler

Overview:
- Sequences which source the 4-digit FND datapath shows: time low (sec.msec), time high (hour.min), DHT11 sensor (humidity/temp) or an error pattern.
- Accepts manual mode-button steps and optional timed auto-rotation.
- Buffers the last valid DHT11 reading and tracks sensor staleness.
- Sits between the stopwatch/clock core, the DHT11 reader and fnd_controller; its disp_sel output drives the datapath source muxes.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency; prescaler terminal count = CLK_FREQ_HZ/1000 - 1.
- DWELL_MS, 3000, auto-rotation dwell per display mode, in ms ticks.
- TIMEOUT_MS, 5000, ms without a valid DHT11 reading before the sensor is declared stale.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- btn_mode  input  1  debounced single-cycle mode-step pulse.
- auto_en  input  1  1 = auto-rotate modes every DWELL_MS.
- dht11_done  input  1  single-cycle pulse when a DHT11 transaction ends.
- dht11_valid  input  1  checksum OK; sampled only when dht11_done = 1.
- rh_data  input  8  humidity from the DHT11 reader.
- t_data  input  8  temperature from the DHT11 reader.
- disp_sel  output  2  00 TIME_L, 01 TIME_H, 10 SENSOR, 11 ERR.
- rh_hold  output  8  last valid humidity.
- t_hold  output  8  last valid temperature.
- sensor_stale  output  1  1 = no valid reading within TIMEOUT_MS, or none yet since reset.
- err_cnt  output  8  count of checksum failures, saturating.
- ms_tick  output  1  one-cycle 1 kHz strobe.

Behaviour:
- Reset (reset=0, async) values:
  - disp_sel=00, rh_hold=0, t_hold=0, sensor_stale=1, err_cnt=0, ms_tick=0.
  - Prescaler, dwell counter and stale counter all cleared.
- Prescaler: counts 0..CLK_FREQ_HZ/1000-1; ms_tick=1 for exactly the cycle after the terminal count, then the prescaler wraps to 0.
- State machine is registered; all disp_sel changes appear 1 cycle after the triggering event.
- Step rule, shared by button and auto-rotation:
  - TIME_L -> TIME_H.
  - TIME_H -> SENSOR if sensor_stale=0, else ERR.
  - SENSOR -> TIME_L.
  - ERR -> TIME_L.
- btn_mode=1 applies one step and clears the dwell counter.
- Auto-rotation:
  - While auto_en=1, the dwell counter increments on each ms_tick.
  - When it reaches DWELL_MS-1 on a ms_tick, apply one step and clear the counter.
  - auto_en=0 clears and holds the dwell counter.
- btn_mode and dwell expiry in the same cycle: exactly one step; dwell counter cleared.
- dht11_done=1 and dht11_valid=1:
  - Latch rh_hold<=rh_data and t_hold<=t_data.
  - sensor_stale<=0; stale counter cleared.
  - If state is ERR and that ERR was entered from the sensor slot, go to SENSOR next cycle.
- dht11_done=1 and dht11_valid=0:
  - No latch; err_cnt increments, saturating at 255.
  - Staleness unaffected.
- Stale counter:
  - Increments on ms_tick while sensor_stale=0.
  - When it reaches TIMEOUT_MS-1 on a ms_tick: sensor_stale<=1.
  - If state is SENSOR at that point, go to ERR next cycle without clearing the dwell counter.
- Track ERR origin with a 1-bit flag, set whenever ERR is entered. ERR entered only via the sensor slot, so a valid reading in ERR always returns to SENSOR.
- Valid reading and btn_mode in the same cycle:
  - Data latched and staleness cleared.
  - Button step wins: from ERR the step goes to TIME_L, not SENSOR.
- Valid reading and stale timeout in the same cycle: valid wins; sensor_stale stays 0 and the counter clears.
- dht11_valid is ignored when dht11_done=0.
- Reset asserted mid-operation: immediate return to the reset values; the held data is lost.

Test Plan:
Bench parameters: CLK_FREQ_HZ=10_000 (10 clk/ms), DWELL_MS=4, TIMEOUT_MS=6.
- After reset release -> disp_sel=00, sensor_stale=1, ms_tick every 10 clk. Three btn_mode pulses -> disp_sel 01, 11 (ERR, stale), 00.
- dht11_done+valid with rh=45, t=23 -> rh_hold=45, t_hold=23, stale=0 next cycle. Two btn pulses from TIME_L -> disp_sel 01, then 10.
- auto_en=1, fresh valid readings every 3 ms -> disp_sel steps 00->01->10->00 every 40 clk. A btn pulse mid-dwell -> one step, next auto step 40 clk later.
- In SENSOR, no readings for 6 ms -> stale=1 and disp_sel=11 one cycle later. A valid reading (rh=60, t=30) -> disp_sel=10 next cycle, holds updated.
- 300 done pulses with valid=0 -> err_cnt saturates at 255; rh_hold/t_hold unchanged; stale counter keeps running.
- Same cycle: btn_mode + valid while in ERR -> disp_sel=00, data latched, stale=0. Reset pulled low mid-dwell -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fnd_disp_scheduler.sv
// -----------------------------------------------------------------------------
// fnd_disp_scheduler
// Chooses which source the 4-digit FND datapath shows: time low (sec.msec),
// time high (hour.min), the buffered DHT11 reading, or an error pattern.
// Modes advance on a mode-button pulse or, when enabled, on a timed rotation.
// The block also keeps the last valid DHT11 reading and tracks how old it is.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        asynchronous active-low reset
//   btn_mode     debounced single-cycle mode-step pulse
//   auto_en      1 = rotate modes every DWELL_MS
//   dht11_done   single-cycle pulse at the end of a DHT11 transaction
//   dht11_valid  checksum OK, qualified by dht11_done
//   rh_data      humidity from the DHT11 reader
//   t_data       temperature from the DHT11 reader
//   disp_sel     00 TIME_L, 01 TIME_H, 10 SENSOR, 11 ERR
//   rh_hold      last valid humidity
//   t_hold       last valid temperature
//   sensor_stale 1 = no valid reading within TIMEOUT_MS (or none yet)
//   err_cnt      saturating count of checksum failures
//   ms_tick      one-cycle 1 kHz strobe
// -----------------------------------------------------------------------------
module fnd_disp_scheduler #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int DWELL_MS    = 3000,
  parameter int TIMEOUT_MS  = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       auto_en,
  input  logic       dht11_done,
  input  logic       dht11_valid,
  input  logic [7:0] rh_data,
  input  logic [7:0] t_data,
  output logic [1:0] disp_sel,
  output logic [7:0] rh_hold,
  output logic [7:0] t_hold,
  output logic       sensor_stale,
  output logic [7:0] err_cnt,
  output logic       ms_tick
);

  localparam int PRESC_N = CLK_FREQ_HZ / 1000;
  localparam int PW = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
  localparam int DW = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
  localparam int TW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;

  localparam logic [PW-1:0] PRESC_TC = PW'(PRESC_N - 1);
  localparam logic [DW-1:0] DWELL_TC = DW'(DWELL_MS - 1);
  localparam logic [TW-1:0] STALE_TC = TW'(TIMEOUT_MS - 1);

  typedef enum logic [1:0] {
    ST_TIME_L = 2'b00,
    ST_TIME_H = 2'b01,
    ST_SENSOR = 2'b10,
    ST_ERR    = 2'b11
  } state_t;

  // Shared step rule for the button and the auto-rotation.
  function automatic state_t step_fn(input state_t cur, input logic stale);
    case (cur)
      ST_TIME_L: step_fn = ST_TIME_H;
      ST_TIME_H: step_fn = stale ? ST_ERR : ST_SENSOR;
      ST_SENSOR: step_fn = ST_TIME_L;
      ST_ERR:    step_fn = ST_TIME_L;
      default:   step_fn = ST_TIME_L;
    endcase
  endfunction

  logic [PW-1:0] presc_r;
  logic [DW-1:0] dwell_r;
  logic [TW-1:0] stale_cnt_r;
  state_t        state_r;
  logic          err_src_r;   // ERR was entered from the sensor slot

  logic valid_evt_s;
  logic invalid_evt_s;
  logic dwell_exp_s;
  logic stale_to_s;

  assign valid_evt_s   = dht11_done & dht11_valid;
  assign invalid_evt_s = dht11_done & ~dht11_valid;
  assign dwell_exp_s   = auto_en & ms_tick & (dwell_r == DWELL_TC);
  // A valid reading in the same cycle cancels the timeout.
  assign stale_to_s    = ms_tick & ~sensor_stale & (stale_cnt_r == STALE_TC) & ~valid_evt_s;

  assign disp_sel = state_r;

  // Millisecond prescaler; ms_tick is the registered terminal-count strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= '0;
      ms_tick <= 1'b0;
    end else if (presc_r == PRESC_TC) begin
      presc_r <= '0;
      ms_tick <= 1'b1;
    end else begin
      presc_r <= presc_r + PW'(1);
      ms_tick <= 1'b0;
    end
  end

  // Dwell counter for auto-rotation; a button step restarts the dwell.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_r <= '0;
    end else if (btn_mode || !auto_en) begin
      dwell_r <= '0;
    end else if (ms_tick) begin
      dwell_r <= (dwell_r == DWELL_TC) ? '0 : dwell_r + DW'(1);
    end else begin
      dwell_r <= dwell_r;
    end
  end

  // Staleness tracking: restarted by a valid reading, frozen once stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stale_cnt_r  <= '0;
      sensor_stale <= 1'b1;
    end else if (valid_evt_s) begin
      stale_cnt_r  <= '0;
      sensor_stale <= 1'b0;
    end else if (stale_to_s) begin
      stale_cnt_r  <= '0;
      sensor_stale <= 1'b1;
    end else if (ms_tick && !sensor_stale) begin
      stale_cnt_r  <= stale_cnt_r + TW'(1);
    end else begin
      stale_cnt_r  <= stale_cnt_r;
    end
  end

  // Sensor data hold registers and saturating checksum-error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rh_hold <= 8'd0;
      t_hold  <= 8'd0;
      err_cnt <= 8'd0;
    end else if (valid_evt_s) begin
      rh_hold <= rh_data;
      t_hold  <= t_data;
    end else if (invalid_evt_s && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end else begin
      err_cnt <= err_cnt;
    end
  end

  // Display-mode state machine; a step (button or dwell) outranks sensor events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_TIME_L;
      err_src_r <= 1'b0;
    end else if (btn_mode || dwell_exp_s) begin
      state_r   <= step_fn(state_r, sensor_stale);
      err_src_r <= (step_fn(state_r, sensor_stale) == ST_ERR);
    end else if (valid_evt_s && (state_r == ST_ERR) && err_src_r) begin
      state_r   <= ST_SENSOR;
      err_src_r <= 1'b0;
    end else if (stale_to_s && (state_r == ST_SENSOR)) begin
      state_r   <= ST_ERR;
      err_src_r <= 1'b1;
    end else begin
      state_r   <= state_r;
      err_src_r <= err_src_r;
    end
  end

endmodule
